hazard_scoreboard: RTL and testbench

- Parametrised successor to the ID-stage hazard detector.
- Owns a STAGES-deep shift register of in-flight writeback records (EXE, MEM, ...) instead of taking per-stage destination inputs.
- Compares NUM_SRC source registers of the ID-stage instruction against those records and raises a stall. In forwarding mode it also emits a per-source forward-select that distinguishes ALU results from late-available load results.
- Sits beside the ID/EXE pipeline register; drives the IF/ID freeze and the EXE operand muxes.

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/hazard_src_match.sv | 33 +++
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard: the in-flight writeback
// record and forward-select width derivation.
package hazard_scoreboard_pkg;

  // Record fields are sized for the largest supported configuration.
  localparam int unsigned REC_DEST_W = 8;
  localparam int unsigned REC_IDX_W  = 4;

  localparam int unsigned FWD_NONE = 0;

  typedef struct packed {
    logic                  valid;
    logic [REC_DEST_W-1:0] dest;
    logic                  wb_en;
    logic [REC_IDX_W-1:0]  avail_idx;
  } stage_rec_t;

  // Forward select encodes register file (0) or stage k-1 (k), so STAGES+1 codes.
  function automatic int unsigned fw_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Matches one ID-stage source register against every in-flight record and
// reports the youngest matching stage and whether its result is forwardable yet.
module hazard_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned IDX_W  = 2
) (
  input  logic                    used,
  input  logic [REG_W-1:0]        addr,
  input  stage_rec_t [STAGES-1:0] recs,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output logic                    avail
);

  // Walk oldest to youngest so the youngest match is the last one assigned.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    avail = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (used && recs[i].valid && recs[i].wb_en &&
          (recs[i].dest == REC_DEST_W'(addr))) begin
        hit   = 1'b1;
        idx   = IDX_W'(i);
        avail = (REC_IDX_W'(i) >= recs[i].avail_idx);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writebacks, raises stalls and,
// in forwarding mode, selects the EXE operand bypass source per operand.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W      = 4,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned LOAD_AVAIL = 1,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned FW        = fw_width(STAGES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_is_load,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     forward_en,
  input  logic                     flush,
  input  logic                     freeze,
  output logic                     hazard_detected,
  output logic [NUM_SRC*FW-1:0]    fwd_sel,
  output logic [CNT_W-1:0]         stall_count
);

  if (REG_W > REC_DEST_W) begin : g_bad_reg_w
    $error("REG_W exceeds record dest width");
  end
  if (LOAD_AVAIL < 1 || LOAD_AVAIL >= STAGES || STAGES >= (1 << REC_IDX_W)) begin : g_bad_avail
    $error("LOAD_AVAIL must satisfy 1 <= LOAD_AVAIL < STAGES");
  end

  stage_rec_t [STAGES-1:0] recs_q, recs_d;
  logic       [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_SRC-1:0] src_hit;
  logic [NUM_SRC-1:0] src_avail;
  logic [FW-1:0]      src_idx [NUM_SRC];
  logic [NUM_SRC-1:0] src_haz;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_src_match #(
      .REG_W  (REG_W),
      .STAGES (STAGES),
      .IDX_W  (FW)
    ) u_match (
      .used  (src_used[s]),
      .addr  (src_addr[s*REG_W +: REG_W]),
      .recs  (recs_q),
      .hit   (src_hit[s]),
      .idx   (src_idx[s]),
      .avail (src_avail[s])
    );
  end

  // A younger unavailable match is final even if an older record could forward.
  always_comb begin
    src_haz = '0;
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_hit[s]) begin
        if (forward_en && src_avail[s]) begin
          fwd_sel[s*FW +: FW] = src_idx[s] + FW'(1);
        end else begin
          src_haz[s]          = 1'b1;
          fwd_sel[s*FW +: FW] = FW'(FWD_NONE);
        end
      end
    end
    hazard_detected = (|src_haz) && id_valid && !flush;
  end

  always_comb begin
    recs_d = recs_q;
    cnt_d  = cnt_q;
    if (!freeze) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        recs_d[i] = recs_q[i-1];
      end
      recs_d[0] = '0;
      if (id_valid && !flush && !hazard_detected) begin
        recs_d[0].valid     = 1'b1;
        recs_d[0].dest      = REC_DEST_W'(id_dest);
        recs_d[0].wb_en     = id_wb_en;
        recs_d[0].avail_idx = id_is_load ? REC_IDX_W'(LOAD_AVAIL) : '0;
      end
      if (hazard_detected && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recs_q <= '0;
      cnt_q  <= '0;
    end else begin
      recs_q <= recs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  localparam int unsigned REG_W = 4;
  localparam int unsigned NSRC  = 3;
  localparam int unsigned FW    = 2;
  localparam int unsigned CNT_W = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  id_valid, id_wb_en, id_is_load;
  logic [REG_W-1:0]      id_dest;
  logic [NSRC*REG_W-1:0] src_addr;
  logic [NSRC-1:0]       src_used;
  logic                  forward_en, flush, freeze;
  logic                  hazard_detected;
  logic [NSRC*FW-1:0]    fwd_sel;
  logic [CNT_W-1:0]      stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard #(
    .REG_W      (REG_W),
    .NUM_SRC    (NSRC),
    .STAGES     (2),
    .LOAD_AVAIL (1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_dest         (id_dest),
    .id_wb_en        (id_wb_en),
    .id_is_load      (id_is_load),
    .src_addr        (src_addr),
    .src_used        (src_used),
    .forward_en      (forward_en),
    .flush           (flush),
    .freeze          (freeze),
    .hazard_detected (hazard_detected),
    .fwd_sel         (fwd_sel),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] d, input logic wb, input logic ld);
    id_valid   = v;
    id_dest    = d;
    id_wb_en   = wb;
    id_is_load = ld;
  endtask

  task automatic set_src(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0,
                         input logic [2:0] used);
    src_addr = {a2, a1, a0};
    src_used = used;
  endtask

  task automatic drain();
    set_id(1'b0, 4'd0, 1'b0, 1'b0);
    set_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 1'b0);
    set_src(4'd0, 4'd0, 4'd0, 3'b000);
    forward_en = 1'b1;
    flush      = 1'b0;
    freeze     = 1'b0;
    #12;
    check_eq("rst_haz", 32'(hazard_detected), 32'd0);
    check_eq("rst_fwd", 32'(fwd_sel), 32'd0);
    check_eq("rst_cnt", 32'(stall_count), 32'd0);
    rst = 1'b1;
    tick();

    // ALU result forwarded from EXE then MEM
    set_id(1'b1, 4'd3, 1'b1, 1'b0);
    #1 check_eq("alu_issue_haz", 32'(hazard_detected), 32'd0);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 1'b0);
    set_src(4'd0, 4'd0, 4'd3, 3'b001);
    #1 check_eq("alu_fwd_exe_haz", 32'(hazard_detected), 32'd0);
    check_eq("alu_fwd_exe_sel", 32'(fwd_sel), 32'h01);
    tick();
    check_eq("alu_fwd_mem_sel", 32'(fwd_sel), 32'h02);
    check_eq("alu_fwd_mem_haz", 32'(hazard_detected), 32'd0);
    tick();

    // Load-use: one bubble, then forward from MEM on src1
    set_id(1'b1, 4'd5, 1'b1, 1'b1);
    set_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 1'b0);
    set_src(4'd0, 4'd5, 4'd0, 3'b010);
    #1 check_eq("ldu_haz", 32'(hazard_detected), 32'd1);
    check_eq("ldu_sel", 32'(fwd_sel), 32'h00);
    tick();
    check_eq("ldu_cnt", 32'(stall_count), 32'd1);
    check_eq("ldu_resolved_haz", 32'(hazard_detected), 32'd0);
    check_eq("ldu_resolved_sel", 32'(fwd_sel), 32'h08);
    tick();
    drain();

    // Stall-only mode: two bubbles
    forward_en = 1'b0;
    set_id(1'b1, 4'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 1'b0);
    set_src(4'd0, 4'd0, 4'd2, 3'b001);
    #1 check_eq("so_haz0", 32'(hazard_detected), 32'd1);
    check_eq("so_sel0", 32'(fwd_sel), 32'h00);
    tick();
    check_eq("so_haz1", 32'(hazard_detected), 32'd1);
    check_eq("so_cnt1", 32'(stall_count), 32'd2);
    tick();
    check_eq("so_haz2", 32'(hazard_detected), 32'd0);
    check_eq("so_sel2", 32'(fwd_sel), 32'h00);
    check_eq("so_cnt2", 32'(stall_count), 32'd3);
    tick();
    drain();

    // Youngest wins: LDR r4 in EXE blocks despite ADD r4 in MEM
    forward_en = 1'b1;
    set_id(1'b1, 4'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd4, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd4, 1'b1, 1'b0);
    set_src(4'd0, 4'd0, 4'd4, 3'b001);
    #1 check_eq("yw_haz", 32'(hazard_detected), 32'd1);
    check_eq("yw_sel", 32'(fwd_sel), 32'h00);

    // Freeze holds records and counter
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("frz_haz", 32'(hazard_detected), 32'd1);
      check_eq("frz_cnt", 32'(stall_count), 32'd3);
    end
    freeze = 1'b0;
    flush  = 1'b1;
    #1 check_eq("flush_haz", 32'(hazard_detected), 32'd0);
    tick();
    check_eq("flush_cnt", 32'(stall_count), 32'd3);
    flush = 1'b0;
    #1 check_eq("flush_bubble_sel", 32'(fwd_sel), 32'h02);
    check_eq("flush_bubble_haz", 32'(hazard_detected), 32'd0);
    tick();
    drain();

    // Async reset mid-stall
    forward_en = 1'b0;
    set_id(1'b1, 4'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 1'b0);
    set_src(4'd0, 4'd0, 4'd6, 3'b001);
    #1 check_eq("ar_pre_haz", 32'(hazard_detected), 32'd1);
    tick();
    check_eq("ar_pre_cnt", 32'(stall_count), 32'd4);
    #2 rst = 1'b0;
    #1 check_eq("ar_haz", 32'(hazard_detected), 32'd0);
    check_eq("ar_cnt", 32'(stall_count), 32'd0);
    #1 rst = 1'b1;
    #1 check_eq("ar_rel_haz", 32'(hazard_detected), 32'd0);
    tick();
    check_eq("ar_rel_cnt", 32'(stall_count), 32'd0);

    // Back-to-back dependent ops: 10 stalls in 15 cycles saturate a 3-bit counter
    set_id(1'b1, 4'd1, 1'b1, 1'b0);
    set_src(4'd0, 4'd0, 4'd1, 3'b001);
    repeat (15) tick();
    check_eq("sat_cnt", 32'(stall_count), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
